// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin share of one 16->32 immediate extender between two requesters.
// Define IMM_EXT_LUI_EN to make mode 10 an upper (LUI) extend; otherwise mode 10 sign-extends.
module imm_ext_arbiter #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req0_valid,
    input  logic [31:0]       i_req0_instr,
    input  logic [1:0]        i_req0_mode,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [31:0]       i_req1_instr,
    input  logic [1:0]        i_req1_mode,
    output logic              o_req1_ready,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_id,
    input  logic              i_out_ready
);
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_id;
    logic              r_last_grant;
    logic              w_accept;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_xfer;
    logic [IMM_W-1:0]  w_imm;
    logic [1:0]        w_mode;
    logic [DATA_W-1:0] w_ext;
    logic              w_unused;

    function automatic logic [DATA_W-1:0] f_ext(input logic [IMM_W-1:0] imm, input logic [1:0] mode);
`ifdef IMM_EXT_LUI_EN
        if (mode == 2'b10) return {imm, {(DATA_W-IMM_W){1'b0}}};
`endif
        return mode == 2'b01 ? {{(DATA_W-IMM_W){1'b0}}, imm} :
               mode == 2'b11 ? {{(DATA_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00} :
                               {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    // last_grant=1 after reset, so requester 0 wins the first contested cycle
    always_comb begin
        w_accept     = rst_n & (!r_out_valid | i_out_ready);
        w_gnt0       = i_req0_valid & (!i_req1_valid | r_last_grant);
        w_gnt1       = i_req1_valid & (!i_req0_valid | !r_last_grant);
        o_req0_ready = w_accept & w_gnt0;
        o_req1_ready = w_accept & w_gnt1;
        w_xfer       = o_req0_ready | o_req1_ready;
        w_imm        = w_gnt1 ? i_req1_instr[IMM_W-1:0] : i_req0_instr[IMM_W-1:0];
        w_mode       = w_gnt1 ? i_req1_mode : i_req0_mode;
        w_ext        = f_ext(w_imm, w_mode);
        w_unused     = ^{i_req0_instr[31:IMM_W], i_req1_instr[31:IMM_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_id     <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_ext;
            r_out_id     <= o_req1_ready;
            r_last_grant <= o_req1_ready;
        end else if (i_out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_id    = r_out_id;
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: directed vectors, per-cycle model comparison plus literal checks.
module tb_imm_ext_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, out_ready = 1'b0;
    logic [31:0] instr0 = '0, instr1 = '0;
    logic [1:0]  mode0 = '0, mode1 = '0;
    logic        rdy0, rdy1, out_valid, out_id;
    logic [31:0] out_data;
    int          checks = 0, errors = 0;

    logic        m_v = 1'b0, m_id = 1'b0, m_last = 1'b1;
    logic [31:0] m_d = '0;

    imm_ext_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req0_valid(v0), .i_req0_instr(instr0), .i_req0_mode(mode0), .o_req0_ready(rdy0),
        .i_req1_valid(v1), .i_req1_instr(instr1), .i_req1_mode(mode1), .o_req1_ready(rdy1),
        .o_out_valid(out_valid), .o_out_data(out_data), .o_out_id(out_id), .i_out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [31:0] instr, input logic [1:0] mode);
        int s;
        s = int'($signed(instr[15:0]));
        case (mode)
            2'b01:   return 32'(instr[15:0]);
            2'b11:   return 32'(s * 4);
`ifdef IMM_EXT_LUI_EN
            2'b10:   return 32'(instr[15:0]) << 16;
`endif
            default: return 32'(s);
        endcase
    endfunction

    // Model: check current cycle, then advance to the state after the coming posedge
    always @(negedge clk) begin
        int  w;
        bit  acc;
        if (!rst_n) begin
            m_v = 1'b0; m_d = '0; m_id = 1'b0; m_last = 1'b1;
            chk("rst_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_data", out_data, 32'd0);
            chk("rst_ready", {30'b0, rdy1, rdy0}, 32'd0);
        end else begin
            acc = !m_v || out_ready;
            w = (v0 && v1) ? (m_last ? 0 : 1) : v0 ? 0 : v1 ? 1 : -1;
            chk("m_valid", {31'b0, out_valid}, {31'b0, m_v});
            chk("m_data", out_data, m_d);
            chk("m_id", {31'b0, out_id}, {31'b0, m_id});
            chk("m_rdy0", {31'b0, rdy0}, {31'b0, acc && w == 0});
            chk("m_rdy1", {31'b0, rdy1}, {31'b0, acc && w == 1});
            if (acc && w >= 0) begin
                m_v = 1'b1;
                m_id = w[0];
                m_last = w[0];
                m_d = w == 1 ? ref_ext(instr1, mode1) : ref_ext(instr0, mode0);
            end else if (out_ready) m_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] lui_a, lui_b;
`ifdef IMM_EXT_LUI_EN
        lui_a = 32'h12340000; lui_b = 32'h80010000;
`else
        lui_a = 32'h00001234; lui_b = 32'hFFFF8001;
`endif
        do_reset();
        // 1: single sign-extend
        v0 = 1; instr0 = 32'h2008FFFC; mode0 = 2'b00; out_ready = 1;
        #1 chk("t1_rdy0", {31'b0, rdy0}, 32'd1);
        tick();
        v0 = 0;
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_data", out_data, 32'hFFFFFFFC);
        chk("t1_id", {31'b0, out_id}, 32'd0);
        tick();
        // 2: alternation with no bubbles
        do_reset();
        v0 = 1; instr0 = 32'h00008000; mode0 = 2'b01;
        v1 = 1; instr1 = 32'h00000004; mode1 = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_valid", {31'b0, out_valid}, 32'd1);
            chk("t2_id", {31'b0, out_id}, i % 2);
            chk("t2_data", out_data, (i % 2) ? 32'h00000010 : 32'h00008000);
        end
        // 3: stall three cycles, then drain + reload in one cycle
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_rdy", {30'b0, rdy1, rdy0}, 32'd0);
            tick();
            chk("t3_data", out_data, 32'h00000010);
            chk("t3_id", {31'b0, out_id}, 32'd1);
        end
        out_ready = 1;
        #1 chk("t3_rdy0", {31'b0, rdy0}, 32'd1);
        tick();
        chk("t3_next", out_data, 32'h00008000);
        v0 = 0; v1 = 0;
        tick();
        // 4: mode 10
        v0 = 1; instr0 = 32'h00001234; mode0 = 2'b10;
        tick();
        chk("t4_a", out_data, lui_a);
        instr0 = 32'h00008001;
        tick();
        chk("t4_b", out_data, lui_b);
        // 5: reset mid-stall
        out_ready = 0;
        tick();
        tick();
        chk("t5_stalled", {31'b0, out_valid}, 32'd1);
        rst_n = 0;
        #1 chk("t5_async", {31'b0, out_valid}, 32'd0);
        v1 = 1; instr1 = 32'h00000004; mode1 = 2'b11; out_ready = 1;
        tick();
        tick();
        rst_n = 1;
        #1 chk("t5_rdy0", {31'b0, rdy0}, 32'd1);
        tick();
        chk("t5_id", {31'b0, out_id}, 32'd0);
        // 6: lone requester 1 keeps winning, then requester 0 gets its turn
        v0 = 0; instr1 = 32'h00000007; mode1 = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_id", {31'b0, out_id}, 32'd1);
            chk("t6_data", out_data, 32'h00000007);
        end
        v0 = 1;
        #1 chk("t6_rdy0", {31'b0, rdy0}, 32'd1);
        tick();
        chk("t6_id0", {31'b0, out_id}, 32'd0);
        v0 = 0; v1 = 0;
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
